// File: rtl/reg_wb_pkg.sv
// Shared types and widths for the register-bank writeback controller.
package reg_wb_pkg;

    localparam int REG_W     = 32;
    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 16;

    typedef enum logic {
        ALU_PRI = 1'b0,
        DRAIN   = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dest;
        logic [REG_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_fifo.sv
// Load-return FIFO for the writeback controller: registered output, no fall-through.
module wb_load_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  wb_entry_t               push_data,
    input  logic                    pop,
    output wb_entry_t               pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [CW-1:0]   wr_ptr;
    logic [CW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointers carry one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Single writer for the 16x32 register bank: merges ALU results and buffered loads.
// Optional REG0_ZERO_EN makes register 0 constant zero (writes consumed, never busy).
module reg_writeback_ctrl
    import reg_wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_dest,
    input  logic [REG_W-1:0]     alu_result,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic [REG_W-1:0]     mem_data,
    output logic                 mem_ready,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_dest,
    output logic                 wr_en,
    output logic [REG_IDX_W-1:0] dest_in,
    output logic [REG_W-1:0]     ldr_in,
    output logic [NUM_REGS-1:0]  busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == STARVE_MAX) ? v : v + 1'b1;
    endfunction

    wb_state_t            state;
    wb_state_t            state_nxt;
    logic [SW-1:0]        starve_cnt;
    logic [SW-1:0]        starve_nxt;
    logic [DW-1:0]        drain_cnt;
    logic [DW-1:0]        drain_nxt;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DW-1:0]        fifo_count;
    wb_entry_t            fifo_head;
    wb_entry_t            mem_entry;

    logic                 take_alu;
    logic                 wr_p0;
    logic [REG_IDX_W-1:0] dest_p0;
    logic [REG_W-1:0]     data_p0;
    logic [NUM_REGS-1:0]  busy_nxt;

    assign mem_entry = '{dest: mem_dest, data: mem_data};
    assign mem_ready = !fifo_full;
    assign fifo_push = mem_valid && mem_ready;

    wb_load_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mem_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Arbitration: ALU has priority until loads have starved STARVE_LIMIT times in a row.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        drain_nxt  = drain_cnt;
        alu_ready  = 1'b0;
        take_alu   = 1'b0;
        fifo_pop   = 1'b0;
        unique case (state)
            ALU_PRI: begin
                alu_ready = 1'b1;
                if (alu_valid)        take_alu = 1'b1;
                else if (!fifo_empty) fifo_pop = 1'b1;
                if (fifo_empty || fifo_pop) starve_nxt = '0;
                else                        starve_nxt = sat_inc(starve_cnt);
                if (starve_nxt == STARVE_MAX) begin
                    state_nxt = DRAIN;
                    // Only loads already queued at entry are drained, bounding DRAIN.
                    drain_nxt = fifo_count + DW'(fifo_push);
                end
            end
            DRAIN: begin
                fifo_pop  = !fifo_empty;
                drain_nxt = drain_cnt - 1'b1;
                if ((drain_cnt == DW'(1)) || (drain_cnt == '0)) begin
                    state_nxt  = ALU_PRI;
                    starve_nxt = '0;
                    drain_nxt  = '0;
                end
            end
        endcase
    end

    // Stage p0: select the write for this cycle
    always_comb begin
        dest_p0 = fifo_head.dest;
        data_p0 = fifo_head.data;
        if (take_alu) begin
            dest_p0 = alu_dest;
            data_p0 = alu_result;
        end
`ifdef REG0_ZERO_EN
        wr_p0 = (take_alu || fifo_pop) && (dest_p0 != '0);
`else
        wr_p0 = take_alu || fifo_pop;
`endif
    end

    // Set after clear so an issue on the same edge as its old writeback stays pending.
    always_comb begin
        busy_nxt = busy;
        if (wr_en) busy_nxt[dest_in] = 1'b0;
`ifdef REG0_ZERO_EN
        if (issue_valid && (issue_dest != '0)) busy_nxt[issue_dest] = 1'b1;
`else
        if (issue_valid) busy_nxt[issue_dest] = 1'b1;
`endif
    end

    // Stage p1: registered bank write port and control state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ALU_PRI;
            starve_cnt <= '0;
            drain_cnt  <= '0;
            wr_en      <= 1'b0;
            dest_in    <= '0;
            ldr_in     <= '0;
            busy       <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            drain_cnt  <= drain_nxt;
            wr_en      <= wr_p0;
            busy       <= busy_nxt;
            if (wr_p0) begin
                dest_in <= dest_p0;
                ldr_in  <= data_p0;
            end
        end
    end

endmodule
